if_fetch: RTL and testbench

//  Instruction-fetch stage: owns the PC, issues requests to instruction memory, buffers one returned

---
 rtl/if_fetch.sv | 73 +++++++
 tb/tb_if_fetch.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage owning the PC, one-deep instruction buffer feeding IF/ID
//   clk, rst_n (sync, active low); pc_write stall, redirect/redirect_pc branch target
//   imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata single-outstanding memory port
//   if_pc/if_Instruction_Code/if_id_write/flush to IF/ID; if_misaligned sticky error
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_write,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_Instruction_Code,
  output logic        if_id_write,
  output logic        flush,
  output logic        if_misaligned
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALT} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, buf_insn, buf_pc;
  logic buf_valid, buf_valid_nx, stale, stale_nx;
  logic redir, mis, load, pend;
  always_comb begin
    if_id_write = buf_valid & pc_write & ~redirect;
    imem_req = (state == S_REQ) & (~buf_valid | if_id_write);
    imem_addr = {pc[31:2], 2'b00};
    flush = redirect;
    if_pc = buf_valid ? buf_pc : 32'h0;
    if_Instruction_Code = buf_valid ? buf_insn : NOP_INSN;
    redir = redirect & (state != S_HALT);
    mis = redir & (redirect_pc[1:0] != 2'b00);
    load = (state == S_WAIT) & imem_rvalid & ~stale & ~redir;
    // a response is still owed to us: redirecting now must drop it when it arrives
    pend = ((state == S_WAIT) & ~imem_rvalid) | ((state == S_REQ) & imem_req & imem_gnt);
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = S_REQ;
      S_REQ:   state_nx = (imem_req & imem_gnt) ? S_WAIT : S_REQ;
      S_WAIT:  state_nx = imem_rvalid ? S_REQ : S_WAIT;
      default: state_nx = S_HALT;
    endcase
    if (redir) state_nx = mis ? S_HALT : pend ? S_WAIT : S_REQ;
    stale_nx = redir ? pend : ((state == S_WAIT) & imem_rvalid) ? 1'b0 : stale;
    pc_nx = redir ? redirect_pc : load ? pc + 32'd4 : pc;
    buf_valid_nx = load | (buf_valid & ~redir & ~if_id_write);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc <= RESET_PC;
      buf_valid <= 1'b0;
      stale <= 1'b0;
      if_misaligned <= 1'b0;
      buf_insn <= NOP_INSN;
      buf_pc <= 32'h0;
    end else begin
      state <= state_nx;
      pc <= pc_nx;
      buf_valid <= buf_valid_nx;
      stale <= stale_nx;
      if_misaligned <= if_misaligned | mis;
      buf_insn <= load ? imem_rdata : buf_insn;
      buf_pc <= load ? pc : buf_pc;
    end
  end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: randomized fetch-stage bench against an in-order fetch-stream reference model
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst_n = 1'b0, pc_write = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic imem_req, if_id_write, flush, if_misaligned;
  logic [31:0] imem_addr, if_pc, if_Instruction_Code;

  if_fetch dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .if_pc(if_pc), .if_Instruction_Code(if_Instruction_Code),
    .if_id_write(if_id_write), .flush(flush), .if_misaligned(if_misaligned)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  logic rst_req = 1'b0;
  bit pend = 0, gnt_always = 1;
  logic [31:0] pend_addr = 32'h0;
  int pend_cnt = 0, lat_fix = 0;
  logic [31:0] exp_pc = 32'h0;
  bit sb_en = 0, prev_hold = 0;
  logic [31:0] prev_addr = 32'h0;
  int writes = 0;
  logic s_req, s_write, s_flush, s_mis, s_gnt;
  logic [31:0] s_addr, s_pc, s_insn;

  // memory image: every word holds its own address
  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a;
  endfunction

  // one clock: drive inputs, play the memory, sample outputs, run the stream model
  task automatic cycle(input logic pw, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst_n = rst_req;
    pc_write = pw;
    redirect = rd;
    redirect_pc = rpc;
    imem_rvalid = pend && pend_cnt == 0;
    imem_rdata = imem_rvalid ? mdata(pend_addr) : 32'hDEAD_BEEF;
    #1;
    imem_gnt = imem_req && !pend && (gnt_always || $urandom_range(1, 0) == 1);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_write = if_id_write; s_pc = if_pc;
    s_insn = if_Instruction_Code; s_flush = flush; s_mis = if_misaligned; s_gnt = imem_gnt;
    if (sb_en && rst_n) begin
      total++;
      if (s_flush !== rd) $display("FAIL flush: got %b want %b", s_flush, rd); else passed++;
      total++;
      if ((s_write & ~(pw & ~rd)) !== 1'b0) $display("FAIL write_gate: if_id_write=%b with pc_write=%b redirect=%b", s_write, pw, rd);
      else passed++;
      if (prev_hold && s_req) begin
        total++;
        if (s_addr !== prev_addr) $display("FAIL addr_stable: got %h want %h", s_addr, prev_addr); else passed++;
      end
      if (s_write) begin
        total++;
        if (s_pc !== exp_pc) $display("FAIL stream_pc: got %h want %h", s_pc, exp_pc); else passed++;
        total++;
        if (s_insn !== mdata(exp_pc)) $display("FAIL stream_insn: got %h want %h", s_insn, mdata(exp_pc)); else passed++;
        exp_pc = exp_pc + 32'd4;
        writes++;
      end
      if (rd) exp_pc = rpc;
    end
    prev_hold = rst_n && s_req && !s_gnt && !rd;
    prev_addr = s_addr;
    if (imem_rvalid) pend = 0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (imem_req && imem_gnt) begin
      pend = 1;
      pend_addr = imem_addr;
      pend_cnt = lat_fix >= 0 ? lat_fix : $urandom_range(3, 0);
    end
  endtask

  task automatic do_reset();
    rst_req = 1'b0;
    sb_en = 0;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    rst_req = 1'b1;
    exp_pc = 32'h0;
    prev_hold = 0;
    sb_en = 1;
  endtask

  task automatic test_reset();
    gnt_always = 1; lat_fix = 0;
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_req !== 1'b0) $display("FAIL rst_req: got %b want 0", s_req); else passed++;
    total++; if (s_addr !== 32'h0) $display("FAIL rst_addr: got %h want 0", s_addr); else passed++;
    total++; if (s_pc !== 32'h0) $display("FAIL rst_if_pc: got %h want 0", s_pc); else passed++;
    total++; if (s_insn !== NOP) $display("FAIL rst_insn: got %h want %h", s_insn, NOP); else passed++;
    total++; if (s_write !== 1'b0) $display("FAIL rst_write: got %b want 0", s_write); else passed++;
    total++; if (s_mis !== 1'b0) $display("FAIL rst_mis: got %b want 0", s_mis); else passed++;
  endtask

  task automatic test_stream();
    gnt_always = 1; lat_fix = 0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (c <= 1) begin
        total++;
        if (s_req !== (c == 1)) $display("FAIL first_req c=%0d: got %b want %b", c, s_req, c == 1); else passed++;
      end
      if (c == 1) begin
        total++;
        if (s_addr !== 32'h0) $display("FAIL first_addr: got %h want 0", s_addr); else passed++;
      end
      total++;
      if (s_write !== (c >= 3 && c % 2 == 1)) $display("FAIL stream_pulse c=%0d: got %b", c, s_write); else passed++;
      if (c >= 3 && c % 2 == 1) begin
        total++;
        if (s_pc !== 32'((c - 3) / 2 * 4)) $display("FAIL stream_seq c=%0d: got %h want %h", c, s_pc, (c - 3) / 2 * 4);
        else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    held = exp_pc;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 32'h0);
      total++; if (s_pc !== held) $display("FAIL stall_pc: got %h want %h", s_pc, held); else passed++;
      total++; if (s_insn !== mdata(held)) $display("FAIL stall_insn: got %h want %h", s_insn, mdata(held)); else passed++;
      total++; if (s_write !== 1'b0) $display("FAIL stall_write: got %b want 0", s_write); else passed++;
      total++; if (s_req !== 1'b0) $display("FAIL stall_req: got %b want 0", s_req); else passed++;
    end
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_write !== 1'b1) $display("FAIL release_write: got %b want 1", s_write); else passed++;
    total++; if (s_pc !== held) $display("FAIL release_pc: got %h want %h", s_pc, held); else passed++;
    total++; if (s_req !== 1'b1 || s_addr !== held + 32'd4) $display("FAIL release_fetch: req=%b addr=%h want 1 %h", s_req, s_addr, held + 32'd4);
    else passed++;
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_write !== 1'b0) $display("FAIL release_once: got %b want 0", s_write); else passed++;
  endtask

  task automatic wait_grant(input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      got = s_req && s_gnt;
    end
    total++; if (!got) $display("FAIL %s_grant_timeout: got none want grant", name); else passed++;
  endtask

  task automatic test_redirect_wait();
    bit seen_req = 0, seen_wr = 0;
    gnt_always = 1; lat_fix = 2;
    wait_grant("redir");
    cycle(1'b1, 1'b1, 32'h100);
    total++; if (s_flush !== 1'b1) $display("FAIL redir_flush: got %b want 1", s_flush); else passed++;
    total++; if (s_write !== 1'b0) $display("FAIL redir_write: got %b want 0", s_write); else passed++;
    for (int i = 0; i < 30 && !seen_wr; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (s_req && !seen_req) begin
        seen_req = 1;
        total++; if (s_addr !== 32'h100) $display("FAIL redir_addr: got %h want 100", s_addr); else passed++;
      end
      if (s_write) begin
        seen_wr = 1;
        total++; if (s_pc !== 32'h100) $display("FAIL redir_pc: got %h want 100", s_pc); else passed++;
      end
    end
    total++; if (!seen_wr) $display("FAIL redir_timeout: got no write want one"); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] want [2];
    int n = 0;
    want[0] = 32'hFFFF_FFFC; want[1] = 32'h0;
    gnt_always = 1; lat_fix = 0;
    cycle(1'b1, 1'b1, 32'hFFFF_FFFC);
    for (int i = 0; i < 40 && n < 2; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (s_write) begin
        total++; if (s_pc !== want[n]) $display("FAIL wrap_pc%0d: got %h want %h", n, s_pc, want[n]); else passed++;
        n++;
      end
    end
    total++; if (n != 2) $display("FAIL wrap_timeout: got %0d writes want 2", n); else passed++;
  endtask

  task automatic test_misaligned();
    cycle(1'b1, 1'b1, 32'h203);
    total++; if (s_flush !== 1'b1) $display("FAIL mis_flush: got %b want 1", s_flush); else passed++;
    sb_en = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'($urandom_range(1, 0)), i == 5, 32'h40);
      total++; if (s_mis !== 1'b1) $display("FAIL mis_sticky: got %b want 1", s_mis); else passed++;
      total++; if (s_req !== 1'b0) $display("FAIL mis_req: got %b want 0", s_req); else passed++;
      total++; if (s_write !== 1'b0) $display("FAIL mis_write: got %b want 0", s_write); else passed++;
    end
    do_reset();
    cycle(1'b1, 1'b0, 32'h0);
    total++; if (s_mis !== 1'b0) $display("FAIL mis_clear: got %b want 0", s_mis); else passed++;
  endtask

  task automatic test_reset_wait();
    bit seen_req = 0, seen_wr = 0;
    gnt_always = 1; lat_fix = 3;
    wait_grant("rstwait");
    rst_req = 1'b0; sb_en = 0;
    cycle(1'b1, 1'b0, 32'h0);
    rst_req = 1'b1; exp_pc = 32'h0; prev_hold = 0; sb_en = 1;
    for (int i = 0; i < 30 && !seen_wr; i++) begin
      cycle(1'b1, 1'b0, 32'h0);
      if (s_req && !seen_req) begin
        seen_req = 1;
        total++; if (s_addr !== 32'h0) $display("FAIL rstwait_addr: got %h want 0", s_addr); else passed++;
      end
      if (s_write) begin
        seen_wr = 1;
        total++; if (s_pc !== 32'h0 || s_insn !== mdata(32'h0)) $display("FAIL rstwait_first: got %h/%h want 0/%h", s_pc, s_insn, mdata(32'h0));
        else passed++;
      end
    end
    total++; if (!seen_wr) $display("FAIL rstwait_timeout: got no write want one"); else passed++;
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    gnt_always = 0; lat_fix = -1;
    writes = 0;
    for (int i = 0; i < 600; i++) begin
      tgt = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      cycle($urandom_range(3, 0) != 0, $urandom_range(24, 0) == 0, tgt);
    end
    total++; if (writes < 30) $display("FAIL random_progress: got %0d writes want >=30", writes); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_wrap();
    test_misaligned();
    test_reset_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
